// File: rtl/store_bus_sequencer_pkg.sv
// Shared definitions for the store bus sequencer: store op encodings, FSM state
// encodings, exception causes, the byte-mask helper and the per-word bus payload.
// Configuration macro used by the including RTL: STORE_MISALIGN_SPLIT_EN.
package store_bus_sequencer_pkg;

  // Store op encodings (riscv_defines.vh STORE_OP_* values)
  localparam int unsigned STORE_OP_WIDTH = 2;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'd0;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'd1;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'd2;

  // Sequencer state encodings
  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  // Exception causes reported on resp_cause
  localparam int unsigned CAUSE_W = 4;
  localparam logic [CAUSE_W-1:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INSTR    = 4'd2;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  // One aligned bus word: lane-positioned data plus its strobes
  typedef struct packed {
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } lane_word_t;

  // Right-justified byte mask for a store op; zero marks an illegal op
  function automatic logic [STRB_W-1:0] store_base_mask(input logic [STORE_OP_WIDTH-1:0] op);
    logic [STRB_W-1:0] m;
    case (op)
      STORE_OP_SB: m = 4'b0001;
      STORE_OP_SH: m = 4'b0011;
      STORE_OP_SW: m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane shifter: positions right-justified store data and its byte
// mask across a two-word window according to the byte offset.
// Ports: addr (byte offset), op (store op), data (right-justified data) ->
//        data64 (lane-positioned data, unselected lanes 0), mask8 (byte mask),
//        split (store touches the upper word), op_valid (op is SB/SH/SW).
module store_lane_shift
  import store_bus_sequencer_pkg::*;
(
  input  logic [1:0]                addr,
  input  logic [STORE_OP_WIDTH-1:0] op,
  input  logic [WORD_W-1:0]         data,
  output logic [2*WORD_W-1:0]       data64,
  output logic [2*STRB_W-1:0]       mask8,
  output logic                      split,
  output logic                      op_valid
);

  logic [STRB_W-1:0] base;
  logic [WORD_W-1:0] byte_mask;

  // Bytes above the op size are cleared so unselected lanes always drive 0
  always_comb begin
    base      = store_base_mask(op);
    op_valid  = (base != 4'b0000);
    byte_mask = {{8{base[3]}}, {8{base[2]}}, {8{base[1]}}, {8{base[0]}}};
    mask8     = 8'(base) << addr;
    data64    = 64'(data & byte_mask) << {addr, 3'b000};
    split     = |mask8[7:4];
  end

endmodule

// File: rtl/store_bus_sequencer.sv
// Store-side sequencer between the LSU and the word-wide data bus. Accepts one
// store at a time, drives aligned bus writes with byte strobes, splits
// word-crossing stores when STORE_MISALIGN_SPLIT_EN is defined (otherwise
// faults them), and reports completion or a fault with a one-cycle pulse.
// Ports: clk/resetn (sync active-low); req_* store request handshake;
//        resp_* completion/fault report; mem_* bus valid/ready write channel.
// Macro: STORE_MISALIGN_SPLIT_EN enables two-transaction misaligned stores.
module store_bus_sequencer
  import store_bus_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [STORE_OP_WIDTH-1:0] req_op,
  input  logic [WORD_W-1:0]         req_data,
  output logic                      resp_valid,
  output logic                      resp_err,
  output logic [CAUSE_W-1:0]        resp_cause,
  output logic [ADDR_WIDTH-1:0]     resp_tval,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [WORD_W-1:0]         mem_wdata,
  output logic [STRB_W-1:0]         mem_wstrb
);

  logic [STATE_W-1:0]    state, state_d;
  logic                  mem_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [WORD_W-1:0]     mem_wdata_d;
  logic [STRB_W-1:0]     mem_wstrb_d;
  logic                  resp_valid_d, resp_err_d;
  logic [CAUSE_W-1:0]    resp_cause_d;
  logic [ADDR_WIDTH-1:0] resp_tval_d;

  logic [2*WORD_W-1:0]   data64;
  logic [2*STRB_W-1:0]   mask8;
  logic                  split, op_valid, misalign_fault;
  logic [ADDR_WIDTH-1:0] lo_addr;

  store_lane_shift u_lane (
    .addr     (req_addr[1:0]),
    .op       (req_op),
    .data     (req_data),
    .data64   (data64),
    .mask8    (mask8),
    .split    (split),
    .op_valid (op_valid)
  );

  assign lo_addr   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign req_ready = (state == S_IDLE);

`ifdef STORE_MISALIGN_SPLIT_EN
  // Upper-word payload captured at accept, issued after the gap cycle
  logic                  split_q, split_d;
  logic [ADDR_WIDTH-1:0] hi_addr_q, hi_addr_d;
  lane_word_t            hi_word_q, hi_word_d;

  assign misalign_fault = 1'b0;
`else
  logic unused_hi;

  // Crossing stores always fault; SH at odd offsets faults even when in-word
  assign misalign_fault = split
                        | ((req_op == STORE_OP_SH) & req_addr[0])
                        | ((req_op == STORE_OP_SW) & (req_addr[1:0] != 2'b00));
  assign unused_hi      = ^{data64[63:32], mask8[7:4]};
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    mem_valid_d  = mem_valid;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_wstrb_d  = mem_wstrb;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_cause_d = '0;
    resp_tval_d  = '0;
`ifdef STORE_MISALIGN_SPLIT_EN
    split_d      = split_q;
    hi_addr_d    = hi_addr_q;
    hi_word_d    = hi_word_q;
`endif
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (!op_valid) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_cause_d = CAUSE_ILLEGAL_INSTR;
            resp_tval_d  = req_addr;
          end else if (misalign_fault) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_cause_d = CAUSE_STORE_MISALIGNED;
            resp_tval_d  = req_addr;
          end else begin
            state_d     = S_LO;
            mem_valid_d = 1'b1;
            mem_addr_d  = lo_addr;
            mem_wdata_d = data64[31:0];
            mem_wstrb_d = mask8[3:0];
`ifdef STORE_MISALIGN_SPLIT_EN
            split_d         = split;
            hi_addr_d       = lo_addr + ADDR_WIDTH'(4);
            hi_word_d.wdata = data64[63:32];
            hi_word_d.wstrb = mask8[7:4];
`endif
          end
        end
      end
      S_LO: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
          if (split_q) begin
            state_d = S_GAP;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
          end
`else
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
`endif
        end
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      S_GAP: begin
        state_d     = S_HI;
        mem_valid_d = 1'b1;
        mem_addr_d  = hi_addr_q;
        mem_wdata_d = hi_word_q.wdata;
        mem_wstrb_d = hi_word_q.wstrb;
      end
      S_HI: begin
        if (mem_ready) begin
          mem_valid_d  = 1'b0;
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end
      end
`endif
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_cause <= '0;
      resp_tval  <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      hi_addr_q  <= '0;
      hi_word_q  <= '0;
`endif
    end else begin
      state      <= state_d;
      mem_valid  <= mem_valid_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_wstrb  <= mem_wstrb_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_cause <= resp_cause_d;
      resp_tval  <= resp_tval_d;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q    <= split_d;
      hi_addr_q  <= hi_addr_d;
      hi_word_q  <= hi_word_d;
`endif
    end
  end

endmodule

// File: tb/tb_store_bus_sequencer.sv
// Directed self-checking bench for store_bus_sequencer. Expected bus beats are
// queued when a request is driven and popped by a bus monitor on handshake.
// Expectations for misaligned stores follow STORE_MISALIGN_SPLIT_EN.
module tb_store_bus_sequencer;

  localparam int unsigned AW = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  logic          clk, resetn;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_op;
  logic [31:0]   req_data;
  logic          resp_valid, resp_err;
  logic [3:0]    resp_cause;
  logic [AW-1:0] resp_tval;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;

  int    n_assert = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  bit    stalled_prev = 1'b0;
  beat_t held;

  store_bus_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_op     (req_op),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_cause (resp_cause),
    .resp_tval  (resp_tval),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    beat_t b;
    b.addr = a;
    b.data = d;
    b.strb = s;
    exp_q.push_back(b);
  endtask

  // Bus monitor: scoreboard pop on handshake, payload stability while stalled
  always @(negedge clk) begin
    beat_t cur, e;
    cur.addr = mem_addr;
    cur.data = mem_wdata;
    cur.strb = mem_wstrb;
    if (resetn && mem_valid) begin
      if (stalled_prev) chk("payload_stable", 68'(cur), 68'(held));
      if (mem_ready) begin
        chk("beat_expected", 68'(exp_q.size() > 0), 68'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat_addr", 68'(mem_addr), 68'(e.addr));
          chk("beat_wdata", 68'(mem_wdata), 68'(e.data));
          chk("beat_wstrb", 68'(mem_wstrb), 68'(e.strb));
        end
      end
      stalled_prev = !mem_ready;
      held = cur;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Drive one request, answer the bus after `delay` stall cycles per beat,
  // then check latency, bus occupancy and the response fields
  task automatic do_req(input string tag, input logic [31:0] addr, input logic [1:0] op,
                        input logic [31:0] data, input int delay, input int exp_lat,
                        input int exp_mv, input logic err, input logic [3:0] cause,
                        input logic [31:0] tval);
    int lat = 0;
    int mv  = 0;
    int w   = 0;
    bit got = 1'b0;
    chk({tag, "_req_ready"}, 68'(req_ready), 68'(1));
    req_addr  = addr;
    req_op    = op;
    req_data  = data;
    req_valid = 1'b1;
    mem_ready = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      tick();
      req_valid = 1'b0;
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end else if (mem_valid) begin
        mv++;
        w++;
        mem_ready = (w > delay);
      end else begin
        w = 0;
        mem_ready = 1'b0;
      end
    end
    mem_ready = 1'b0;
    chk({tag, "_resp_seen"}, 68'(got), 68'(1));
    chk({tag, "_latency"}, 68'(lat), 68'(exp_lat));
    chk({tag, "_mem_valid_cycles"}, 68'(mv), 68'(exp_mv));
    chk({tag, "_resp_err"}, 68'(resp_err), 68'(err));
    chk({tag, "_resp_cause"}, 68'(resp_cause), 68'(cause));
    chk({tag, "_resp_tval"}, 68'(resp_tval), 68'(tval));
    tick();
    chk({tag, "_resp_pulse"}, 68'(resp_valid), 68'(0));
    chk({tag, "_ready_after"}, 68'(req_ready), 68'(1));
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_op    = 2'd0;
    req_data  = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 68'(req_ready), 68'(1));
    chk("rst_mem_valid", 68'(mem_valid), 68'(0));
    chk("rst_mem_addr", 68'(mem_addr), 68'(0));
    chk("rst_mem_wdata", 68'(mem_wdata), 68'(0));
    chk("rst_mem_wstrb", 68'(mem_wstrb), 68'(0));
    chk("rst_resp", 68'({resp_valid, resp_err, resp_cause, resp_tval}), 68'(0));
    resetn = 1'b1;
    tick();

    // SB at offset 1
    push(32'h0000_3000, 32'h0000_A500, 4'b0010);
    do_req("sb_off1", 32'h0000_3001, 2'd0, 32'h0000_00A5, 0, 2, 1, 1'b0, 4'd0, 32'h0);

    // SB at offset 2 with junk in the upper request bytes
    push(32'h0000_3000, 32'h005A_0000, 4'b0100);
    do_req("sb_junk", 32'h0000_3002, 2'd0, 32'hFFFF_FF5A, 0, 2, 1, 1'b0, 4'd0, 32'h0);

    // Aligned SH at offset 2
    push(32'h0000_0000, 32'h8001_0000, 4'b1100);
    do_req("sh_off2", 32'h0000_0002, 2'd1, 32'hFFFF_8001, 0, 2, 1, 1'b0, 4'd0, 32'h0);

    // Illegal op
    do_req("illegal_op", 32'h0000_0100, 2'd3, 32'h1234_5678, 0, 1, 0, 1'b1, 4'd2, 32'h0000_0100);

`ifdef STORE_MISALIGN_SPLIT_EN
    push(32'h0000_1000, 32'hEF00_0000, 4'b1000);
    push(32'h0000_1004, 32'h0000_00BE, 4'b0001);
    do_req("sh_cross", 32'h0000_1003, 2'd1, 32'h0000_BEEF, 0, 4, 2, 1'b0, 4'd0, 32'h0);

    push(32'h0000_1000, 32'h0012_3400, 4'b0110);
    do_req("sh_off1", 32'h0000_1001, 2'd1, 32'h0000_1234, 0, 2, 1, 1'b0, 4'd0, 32'h0);

    push(32'h0000_2000, 32'h3344_0000, 4'b1100);
    push(32'h0000_2004, 32'h0000_1122, 4'b0011);
    do_req("sw_stall", 32'h0000_2002, 2'd2, 32'h1122_3344, 3, 10, 8, 1'b0, 4'd0, 32'h0);

    push(32'hFFFF_FFFC, 32'hC3D4_0000, 4'b1100);
    push(32'h0000_0000, 32'h0000_A1B2, 4'b0011);
    do_req("sw_wrap", 32'hFFFF_FFFE, 2'd2, 32'hA1B2_C3D4, 0, 4, 2, 1'b0, 4'd0, 32'h0);

    push(32'h0000_4000, 32'hADBE_EF00, 4'b1110);
    push(32'h0000_4004, 32'h0000_00DE, 4'b0001);
    do_req("sw_off1", 32'h0000_4001, 2'd2, 32'hDEAD_BEEF, 0, 4, 2, 1'b0, 4'd0, 32'h0);

    // Reset while the upper half waits for mem_ready
    push(32'h0000_5000, 32'h7700_0000, 4'b1000);
    push(32'h0000_5004, 32'h0066_5544, 4'b0111);
    req_addr  = 32'h0000_5003;
    req_op    = 2'd2;
    req_data  = 32'h6655_4477;
    req_valid = 1'b1;
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    chk("abort_gap", 68'(mem_valid), 68'(0));
    tick();
    chk("abort_hi_valid", 68'(mem_valid), 68'(1));
`else
    do_req("sh_cross", 32'h0000_1003, 2'd1, 32'h0000_BEEF, 0, 1, 0, 1'b1, 4'd6, 32'h0000_1003);
    do_req("sh_off1", 32'h0000_1001, 2'd1, 32'h0000_1234, 0, 1, 0, 1'b1, 4'd6, 32'h0000_1001);
    do_req("sw_off2", 32'h0000_2002, 2'd2, 32'h1122_3344, 3, 1, 0, 1'b1, 4'd6, 32'h0000_2002);
    do_req("sw_wrap", 32'hFFFF_FFFE, 2'd2, 32'hA1B2_C3D4, 0, 1, 0, 1'b1, 4'd6, 32'hFFFF_FFFE);
    do_req("sw_off1", 32'h0000_4001, 2'd2, 32'h0000_0000, 0, 1, 0, 1'b1, 4'd6, 32'h0000_4001);

    // Aligned SW with a stalled bus
    push(32'h0000_2000, 32'h1122_3344, 4'b1111);
    do_req("sw_stall", 32'h0000_2000, 2'd2, 32'h1122_3344, 3, 5, 4, 1'b0, 4'd0, 32'h0);

    // Reset while the only beat waits for mem_ready
    push(32'h0000_5000, 32'h6655_4477, 4'b1111);
    req_addr  = 32'h0000_5000;
    req_op    = 2'd2;
    req_data  = 32'h6655_4477;
    req_valid = 1'b1;
    mem_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("abort_lo_valid", 68'(mem_valid), 68'(1));
`endif
    resetn = 1'b0;
    tick();
    chk("abort_mem_valid", 68'(mem_valid), 68'(0));
    chk("abort_resp", 68'({resp_valid, resp_err, resp_cause, resp_tval}), 68'(0));
    chk("abort_mem_wstrb", 68'(mem_wstrb), 68'(0));
    void'(exp_q.pop_back());
    resetn = 1'b1;
    tick();
    chk("abort_ready", 68'(req_ready), 68'(1));
    mem_ready = 1'b1;
    tick();
    chk("abort_no_reissue", 68'(mem_valid), 68'(0));
    mem_ready = 1'b0;

    push(32'h0000_0010, 32'hCAFE_F00D, 4'b1111);
    do_req("sw_after_rst", 32'h0000_0010, 2'd2, 32'hCAFE_F00D, 0, 2, 1, 1'b0, 4'd0, 32'h0);

    tick();
    chk("scoreboard_empty", 68'(exp_q.size()), 68'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
